// File: rtl/wb_apb_bridge_pkg.sv
// Shared types and address-map defaults for the Wishbone-to-APB bridge.
package wb_apb_bridge_pkg;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned ADDR_W = 32;
   localparam int unsigned SEL_W  = 4;
   localparam int unsigned CNT_W  = 8;

   localparam logic [ADDR_W-1:0] DEFAULT_BASE_ADDR    = 32'h3000_0000;
   localparam logic [ADDR_W-1:0] DEFAULT_ADDR_MASK    = 32'hFFFF_FF00;
   localparam logic [DATA_W-1:0] DEFAULT_TIMEOUT_DATA = 32'hDEAD_BEEF;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2,
      ACK    = 2'd3
   } state_e;

endpackage

// File: rtl/wb_apb_bridge.sv
// Single-slave Wishbone classic to APB bridge with a bounded ACCESS wait timeout.
module wb_apb_bridge
   import wb_apb_bridge_pkg::*;
#(
   parameter logic [ADDR_W-1:0] BASE_ADDR      = DEFAULT_BASE_ADDR,
   parameter logic [ADDR_W-1:0] ADDR_MASK      = DEFAULT_ADDR_MASK,
   parameter int unsigned       TIMEOUT_CYCLES = 16,
   parameter logic [DATA_W-1:0] TIMEOUT_DATA   = DEFAULT_TIMEOUT_DATA
) (
   input  logic              clock,
   input  logic              rst_n,
   input  logic              wb_cyc_i,
   input  logic              wb_stb_i,
   input  logic              wb_we_i,
   input  logic [SEL_W-1:0]  wb_sel_i,
   input  logic [ADDR_W-1:0] wb_adr_i,
   input  logic [DATA_W-1:0] wb_dat_i,
   output logic              wb_ack_o,
   output logic [DATA_W-1:0] wb_dat_o,
   output logic [ADDR_W-1:0] apb_addr,
   output logic              apb_sel,
   output logic              apb_ena,
   output logic              apb_write,
   output logic [DATA_W-1:0] apb_wdata,
   output logic [SEL_W-1:0]  apb_pstb,
   input  logic [DATA_W-1:0] apb_rdata,
   input  logic              apb_rready,
   output logic              apb_timeout
);

   localparam logic [CNT_W-1:0] TIMEOUT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              cyc_lost_q, cyc_lost_d;
   logic              launch;

   logic              ack_d;
   logic [DATA_W-1:0] dat_d;
   logic [ADDR_W-1:0] addr_d;
   logic              sel_d;
   logic              ena_d;
   logic              write_d;
   logic [DATA_W-1:0] wdata_d;
   logic [SEL_W-1:0]  pstb_d;
   logic              timeout_d;

   // Start a transfer for a fresh strobe that falls inside the decoded window.
   assign launch = wb_cyc_i & wb_stb_i & ~wb_ack_o
                 & ((wb_adr_i & ADDR_MASK) == BASE_ADDR);

   // State, wait counter and every output are registered here.
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         cyc_lost_q  <= 1'b0;
         wb_ack_o    <= 1'b0;
         wb_dat_o    <= '0;
         apb_addr    <= '0;
         apb_sel     <= 1'b0;
         apb_ena     <= 1'b0;
         apb_write   <= 1'b0;
         apb_wdata   <= '0;
         apb_pstb    <= '0;
         apb_timeout <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         cyc_lost_q  <= cyc_lost_d;
         wb_ack_o    <= ack_d;
         wb_dat_o    <= dat_d;
         apb_addr    <= addr_d;
         apb_sel     <= sel_d;
         apb_ena     <= ena_d;
         apb_write   <= write_d;
         apb_wdata   <= wdata_d;
         apb_pstb    <= pstb_d;
         apb_timeout <= timeout_d;
      end
   end

   // Next state and next values of the registered outputs.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      cyc_lost_d = cyc_lost_q;
      ack_d      = 1'b0;
      dat_d      = wb_dat_o;
      addr_d     = apb_addr;
      sel_d      = apb_sel;
      ena_d      = apb_ena;
      write_d    = apb_write;
      wdata_d    = apb_wdata;
      pstb_d     = apb_pstb;
      timeout_d  = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (launch) begin
               state_d    = SETUP;
               cnt_d      = '0;
               cyc_lost_d = 1'b0;
               addr_d     = wb_adr_i & ~ADDR_MASK;
               write_d    = wb_we_i;
               wdata_d    = wb_dat_i;
               pstb_d     = wb_sel_i;
               sel_d      = 1'b1;
               ena_d      = 1'b0;
            end
         end

         SETUP: begin
            state_d = ACCESS;
            ena_d   = 1'b1;
            if (!wb_cyc_i) cyc_lost_d = 1'b1;
         end

         ACCESS: begin
            // APB cannot abort, so a dropped cycle only suppresses the ack.
            if (!wb_cyc_i) cyc_lost_d = 1'b1;
            if (apb_rready) begin
               if (!apb_write) dat_d = apb_rdata;
               state_d = ACK;
               sel_d   = 1'b0;
               ena_d   = 1'b0;
               ack_d   = wb_cyc_i & ~cyc_lost_q;
            end else if (cnt_q == TIMEOUT_LIMIT) begin
               if (!apb_write) dat_d = TIMEOUT_DATA;
               state_d   = ACK;
               sel_d     = 1'b0;
               ena_d     = 1'b0;
               ack_d     = wb_cyc_i & ~cyc_lost_q;
               timeout_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         ACK: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_wb_apb_bridge.sv
// Directed self-checking bench for wb_apb_bridge.
module tb_wb_apb_bridge;

   logic        clock;
   logic        rst_n;
   logic        wb_cyc_i;
   logic        wb_stb_i;
   logic        wb_we_i;
   logic [3:0]  wb_sel_i;
   logic [31:0] wb_adr_i;
   logic [31:0] wb_dat_i;
   logic        wb_ack_o;
   logic [31:0] wb_dat_o;
   logic [31:0] apb_addr;
   logic        apb_sel;
   logic        apb_ena;
   logic        apb_write;
   logic [31:0] apb_wdata;
   logic [3:0]  apb_pstb;
   logic [31:0] apb_rdata;
   logic        apb_rready;
   logic        apb_timeout;

   int vectors     = 0;
   int miscompares = 0;

   wb_apb_bridge #(
      .BASE_ADDR      (32'h3000_0000),
      .ADDR_MASK      (32'hFFFF_FF00),
      .TIMEOUT_CYCLES (16),
      .TIMEOUT_DATA   (32'hDEAD_BEEF)
   ) dut (
      .clock       (clock),
      .rst_n       (rst_n),
      .wb_cyc_i    (wb_cyc_i),
      .wb_stb_i    (wb_stb_i),
      .wb_we_i     (wb_we_i),
      .wb_sel_i    (wb_sel_i),
      .wb_adr_i    (wb_adr_i),
      .wb_dat_i    (wb_dat_i),
      .wb_ack_o    (wb_ack_o),
      .wb_dat_o    (wb_dat_o),
      .apb_addr    (apb_addr),
      .apb_sel     (apb_sel),
      .apb_ena     (apb_ena),
      .apb_write   (apb_write),
      .apb_wdata   (apb_wdata),
      .apb_pstb    (apb_pstb),
      .apb_rdata   (apb_rdata),
      .apb_rready  (apb_rready),
      .apb_timeout (apb_timeout)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Absolute time bound so the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic wb_start(input logic we, input logic [31:0] adr,
                           input logic [31:0] dat, input logic [3:0] sel);
      wb_cyc_i = 1'b1;
      wb_stb_i = 1'b1;
      wb_we_i  = we;
      wb_adr_i = adr;
      wb_dat_i = dat;
      wb_sel_i = sel;
   endtask

   task automatic wb_end();
      wb_cyc_i = 1'b0;
      wb_stb_i = 1'b0;
      wb_we_i  = 1'b0;
   endtask

   initial begin
      int n;
      int pulses;
      int activity;

      rst_n      = 1'b0;
      wb_cyc_i   = 1'b0;
      wb_stb_i   = 1'b0;
      wb_we_i    = 1'b0;
      wb_sel_i   = 4'h0;
      wb_adr_i   = 32'h0;
      wb_dat_i   = 32'h0;
      apb_rdata  = 32'h0;
      apb_rready = 1'b1;

      // Reset values
      step();
      step();
      check("rst_ack",     32'(wb_ack_o),    32'h0);
      check("rst_dat",     wb_dat_o,         32'h0);
      check("rst_sel",     32'(apb_sel),     32'h0);
      check("rst_ena",     32'(apb_ena),     32'h0);
      check("rst_write",   32'(apb_write),   32'h0);
      check("rst_addr",    apb_addr,         32'h0);
      check("rst_wdata",   apb_wdata,        32'h0);
      check("rst_pstb",    32'(apb_pstb),    32'h0);
      check("rst_timeout", 32'(apb_timeout), 32'h0);
      rst_n = 1'b1;
      step();

      // Zero-wait write of A5 to offset 0
      wb_start(1'b1, 32'h3000_0000, 32'h0000_00A5, 4'hF);
      step();
      check("wr_setup_sel",  32'(apb_sel),   32'h1);
      check("wr_setup_ena",  32'(apb_ena),   32'h0);
      check("wr_setup_addr", apb_addr,       32'h0);
      check("wr_setup_we",   32'(apb_write), 32'h1);
      check("wr_setup_wd",   apb_wdata,      32'h0000_00A5);
      check("wr_setup_pstb", 32'(apb_pstb),  32'hF);
      check("wr_setup_ack",  32'(wb_ack_o),  32'h0);
      step();
      check("wr_acc_sel",    32'(apb_sel),   32'h1);
      check("wr_acc_ena",    32'(apb_ena),   32'h1);
      check("wr_acc_addr",   apb_addr,       32'h0);
      check("wr_acc_wd",     apb_wdata,      32'h0000_00A5);
      check("wr_acc_ack",    32'(wb_ack_o),  32'h0);
      step();
      check("wr_ack",        32'(wb_ack_o),  32'h1);
      check("wr_ack_sel",    32'(apb_sel),   32'h0);
      check("wr_ack_ena",    32'(apb_ena),   32'h0);
      check("wr_dat_hold",   wb_dat_o,       32'h0);
      step();
      check("wr_ack_once",   32'(wb_ack_o),  32'h0);
      wb_end();
      step();

      // Zero-wait read of offset 4
      apb_rdata = 32'h1234_5678;
      wb_start(1'b0, 32'h3000_0004, 32'h0, 4'hF);
      step();
      check("rd_setup_addr", apb_addr,       32'h4);
      check("rd_setup_we",   32'(apb_write), 32'h0);
      check("rd_setup_sel",  32'(apb_sel),   32'h1);
      step();
      check("rd_acc_ena",    32'(apb_ena),   32'h1);
      check("rd_acc_we",     32'(apb_write), 32'h0);
      step();
      check("rd_ack",        32'(wb_ack_o),  32'h1);
      check("rd_dat",        wb_dat_o,       32'h1234_5678);
      step();
      check("rd_ack_once",   32'(wb_ack_o),  32'h0);
      wb_end();
      step();

      // Read with three wait states; APB signals must hold through ACCESS
      apb_rready = 1'b0;
      apb_rdata  = 32'hCAFE_0001;
      wb_start(1'b0, 32'h3000_0008, 32'h5555_AAAA, 4'h3);
      step();
      step();
      for (int i = 0; i < 4; i++) begin
         check("wt_sel",   32'(apb_sel),   32'h1);
         check("wt_ena",   32'(apb_ena),   32'h1);
         check("wt_addr",  apb_addr,       32'h8);
         check("wt_we",    32'(apb_write), 32'h0);
         check("wt_wdata", apb_wdata,      32'h5555_AAAA);
         check("wt_pstb",  32'(apb_pstb),  32'h3);
         check("wt_ack",   32'(wb_ack_o),  32'h0);
         if (i == 3) apb_rready = 1'b1;
         if (i < 3) step();
      end
      step();
      check("wt_ack_late", 32'(wb_ack_o), 32'h1);
      check("wt_dat",      wb_dat_o,      32'hCAFE_0001);
      step();
      wb_end();
      step();

      // Slave never ready: timeout after 16 waits
      apb_rready = 1'b0;
      apb_rdata  = 32'h0BAD_0BAD;
      wb_start(1'b0, 32'h3000_000C, 32'h0, 4'hF);
      step();
      n = 0;
      pulses = 0;
      while (!wb_ack_o && n < 40) begin
         step();
         n++;
         if (apb_timeout) pulses++;
      end
      check("to_latency", 32'(n),           32'd18);
      check("to_ack",     32'(wb_ack_o),    32'h1);
      check("to_pulse",   32'(apb_timeout), 32'h1);
      check("to_dat",     wb_dat_o,         32'hDEAD_BEEF);
      check("to_sel",     32'(apb_sel),     32'h0);
      step();
      if (apb_timeout) pulses++;
      check("to_pulses",  32'(pulses),      32'd1);
      check("to_ack_end", 32'(wb_ack_o),    32'h0);
      wb_end();
      step();

      // Outside the window: nothing happens for 50 cycles
      apb_rready = 1'b1;
      wb_start(1'b0, 32'h3000_0100, 32'h0, 4'hF);
      activity = 0;
      for (int i = 0; i < 50; i++) begin
         step();
         if (apb_sel || apb_ena || wb_ack_o) activity++;
      end
      check("oow_activity", 32'(activity), 32'd0);
      check("oow_dat",      wb_dat_o,      32'hDEAD_BEEF);
      wb_end();
      step();

      // Reset asserted during ACCESS clears outputs at once
      apb_rready = 1'b0;
      wb_start(1'b0, 32'h3000_0010, 32'h0, 4'hF);
      step();
      step();
      check("mr_in_access", 32'(apb_ena), 32'h1);
      rst_n = 1'b0;
      #1;
      check("mr_sel",   32'(apb_sel),   32'h0);
      check("mr_ena",   32'(apb_ena),   32'h0);
      check("mr_ack",   32'(wb_ack_o),  32'h0);
      check("mr_dat",   wb_dat_o,       32'h0);
      check("mr_addr",  apb_addr,       32'h0);
      check("mr_pstb",  32'(apb_pstb),  32'h0);
      wb_end();
      step();
      rst_n = 1'b1;
      step();

      // Fresh read after reset release
      apb_rready = 1'b1;
      apb_rdata  = 32'h0BAD_F00D;
      wb_start(1'b0, 32'h3000_0014, 32'h0, 4'hF);
      step();
      check("pr_addr", apb_addr, 32'h14);
      step();
      step();
      check("pr_ack", 32'(wb_ack_o), 32'h1);
      check("pr_dat", wb_dat_o,      32'h0BAD_F00D);
      step();
      wb_end();
      step();

      // Cycle dropped in SETUP: APB finishes, no ack
      wb_start(1'b1, 32'h3000_0018, 32'h0000_0077, 4'h1);
      step();
      wb_end();
      step();
      check("cd_acc_sel", 32'(apb_sel), 32'h1);
      check("cd_acc_ena", 32'(apb_ena), 32'h1);
      check("cd_wdata",   apb_wdata,    32'h0000_0077);
      activity = 0;
      for (int i = 0; i < 4; i++) begin
         step();
         if (wb_ack_o) activity++;
      end
      check("cd_no_ack", 32'(activity), 32'd0);
      check("cd_sel_end", 32'(apb_sel), 32'h0);
      check("cd_dat",     wb_dat_o,     32'h0BAD_F00D);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/wb_apb_bridge.md
# wb_apb_bridge

Single-slave bridge from the Caravel Wishbone classic bus to the APB interface of the GPIO expander. It decodes a configurable address window, converts each Wishbone cycle into one APB SETUP/ACCESS transfer, and returns read data and acknowledge to the Wishbone master. A bounded wait timeout prevents the Wishbone bus from hanging if the APB slave never asserts ready.

## Interface
Parameters:
- BASE_ADDR, 32'h3000_0000: base of the decoded window.
- ADDR_MASK, 32'hFFFF_FF00: bits compared against BASE_ADDR. Unmasked bits form the APB offset.
- TIMEOUT_CYCLES, 16: maximum ACCESS cycles with ready low before abort. Legal range 1..255.
- TIMEOUT_DATA, 32'hDEAD_BEEF: read data returned on timeout.

Ports:
- clock, in, 1: single clock for the whole block.
- rst_n, in, 1: reset, asynchronous assert, active-low.
- wb_cyc_i, in, 1: Wishbone cycle.
- wb_stb_i, in, 1: Wishbone strobe.
- wb_we_i, in, 1: 1 = write.
- wb_sel_i, in, 4: byte selects.
- wb_adr_i, in, 32: byte address.
- wb_dat_i, in, 32: write data.
- wb_ack_o, out, 1: one-cycle acknowledge.
- wb_dat_o, out, 32: read data.
- apb_addr, out, 32: offset, equal to wb_adr_i & ~ADDR_MASK.
- apb_sel, out, 1: APB select.
- apb_ena, out, 1: APB enable.
- apb_write, out, 1: APB write.
- apb_wdata, out, 32: APB write data.
- apb_pstb, out, 4: APB strobes, copied from wb_sel_i.
- apb_rdata, in, 32: APB read data.
- apb_rready, in, 1: APB ready.
- apb_timeout, out, 1: one-cycle pulse when a transfer is aborted.

## Operation
- All outputs are registered. The state machine has four states: IDLE, SETUP, ACCESS, ACK.
- IDLE:
  - Launch condition: wb_cyc_i & wb_stb_i & ~wb_ack_o & ((wb_adr_i & ADDR_MASK) == BASE_ADDR).
  - On launch, latch address offset, we, sel and wdata, then go to SETUP.
  - An address outside the window is ignored: no ack, no APB activity.
- SETUP: apb_sel=1, apb_ena=0. Always advances to ACCESS after one cycle.
- ACCESS: apb_sel=1, apb_ena=1.
  - If apb_rready is sampled high: capture apb_rdata into wb_dat_o on reads, then go to ACK.
  - Otherwise increment the wait counter.
  - When the counter reaches TIMEOUT_CYCLES: load TIMEOUT_DATA into wb_dat_o on reads, pulse apb_timeout, go to ACK. Writes are acknowledged and silently dropped.
- ACK:
  - apb_sel=0, apb_ena=0.
  - wb_ack_o=1 for exactly one cycle, only if wb_cyc_i is still high. Otherwise no ack is issued.
  - Return to IDLE.
- wb_dat_o changes only on read completion or timeout; it holds its value otherwise, including across writes.
- If wb_cyc_i drops during SETUP or ACCESS, the APB transfer still completes (APB cannot abort); only the ack is suppressed.
- APB address, write, wdata and pstb are held stable from SETUP through the end of ACCESS.
- The wait counter is 8 bits and is cleared on entry to SETUP.

## Timing
- Reset values: wb_ack_o=0, wb_dat_o=0, apb_sel=0, apb_ena=0, apb_write=0, apb_addr=0, apb_wdata=0, apb_pstb=0, apb_timeout=0, state=IDLE, counter=0.
- Reset mid-transfer: all outputs clear immediately and asynchronously. No ack is issued for the interrupted cycle.
- Latency with a zero-wait slave: strobe sampled at edge t0 → apb_sel high after t0 → apb_ena high after t1 → ready sampled at t2 → wb_ack_o high during cycle t2–t3. Each added APB wait state adds one cycle.
- Back-to-back transfers: the next launch is possible at the edge after the ack cycle. Minimum is 4 cycles per transfer.
- The GPIO slave registers read data during SETUP and ties ready high, so apb_rdata is valid in ACCESS and transfers complete with zero waits.
- Timeout with TIMEOUT_CYCLES=N: ack occurs N+3 cycles after launch; apb_timeout pulses in the same cycle as the ack.

## Structure
- Shared package holds:
  - the state enumeration (IDLE, SETUP, ACCESS, ACK);
  - default BASE_ADDR, ADDR_MASK and TIMEOUT_DATA constants, shared with the top-level address map.
- No sub-module is required. The wait counter stays inline in the state machine.

## Test plan
- Write 32'h0000_00A5 to 32'h3000_0000, zero-wait slave: one SETUP cycle, then one ACCESS cycle with apb_addr=0, apb_write=1, apb_wdata=A5, pstb=4'hF; ack on cycle 3.
- Read 32'h3000_0004, slave drives 32'h1234_5678: wb_dat_o=32'h1234_5678 coincident with wb_ack_o; apb_write=0 throughout.
- Slave holds ready low for 3 cycles: ACCESS lasts 4 cycles with apb_addr/apb_write/apb_wdata/apb_pstb held stable and the read data captured; ack 3 cycles later than the zero-wait case.
- Slave never asserts ready, TIMEOUT_CYCLES=16, read: ack at cycle 19 with wb_dat_o=32'hDEAD_BEEF, apb_timeout pulses once, apb_sel deasserts.
- Access to 32'h3000_0100 (outside the window): no APB activity and no ack for 50 cycles.
- Mid-transfer edge cases:
  - rst_n pulled low during ACCESS: all outputs 0 immediately.
  - After release, a new read completes normally.
  - wb_cyc_i dropped during SETUP: the APB transfer finishes and no ack is issued.
